// File: rtl/disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit, common-anode 7-segment
// display with a decimal point.
//
// Each enabled digit gets one slot. A slot is BLANK_CYC dead cycles, with
// every anode off, followed by SCAN_DIV drive cycles. Disabled digits are
// skipped. When the scan wraps back to a lower or equal digit index, a new
// frame starts. At that point all four inputs are captured into a shadow
// register, so the display cannot tear mid-frame. A free-running 4-bit PWM
// counter gates the drive cycles to dim the display.
//
// Parameters:
//   SCAN_DIV   clock cycles per digit drive window (>= 1)
//   BLANK_CYC  clock cycles of dead time before each drive window (>= 1)
//
// Ports:
//   clk         clock; all state changes on its rising edge
//   reset       asynchronous, active-high reset
//   in0..in3    digit segment patterns, active low, bit 7 = decimal point
//   en_mask     bit i enables digit i in the scan
//   bright      brightness, 15 = full on, 0 = dark
//   an          digit anodes, active low, at most one bit low (registered)
//   sseg        segment bus, active low (registered)
//   frame_tick  one-cycle pulse in the first cycle of each frame (registered)
// ---------------------------------------------------------------------------
module disp_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [3:0] en_mask,
    input  logic [3:0] bright,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    // The slot counter runs 0..N-1, so it must hold the larger of the two
    // window lengths minus one.
    localparam int unsigned MaxCyc = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] ScanLast  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StDrive = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      pwm_q, pwm_d;
    logic [7:0]      shadow_q [4];
    logic [7:0]      shadow_d [4];
    logic [3:0]      an_d;
    logic [7:0]      sseg_d;
    logic            frame_start;

    // Index of the lowest set bit of m. m is known to be non-zero here.
    function automatic logic [1:0] lowest_en(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Next enabled digit strictly above cur, wrapping modulo 4. If cur is
    // the only enabled digit, this returns cur itself (k = 4).
    function automatic logic [1:0] next_en(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] cand;
        r = cur;
        // Walk downward so the smallest step wins.
        for (int k = 4; k >= 1; k--) begin
            cand = cur + 2'(k);
            if (m[cand]) r = cand;
        end
        return r;
    endfunction

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pwm_d       = pwm_q + 4'd1;
        shadow_d    = shadow_q;
        frame_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en_mask != 4'd0) begin
                    idx_d       = lowest_en(en_mask);
                    frame_start = 1'b1;
                    cnt_d       = '0;
                    state_d     = StBlank;
                end
            end
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    cnt_d   = '0;
                    state_d = StDrive;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrive: begin
                if (cnt_q == ScanLast) begin
                    cnt_d = '0;
                    // The mask is sampled only at slot end, so slot timing
                    // never depends on mid-slot mask changes.
                    if (en_mask == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        idx_d       = next_en(idx_q, en_mask);
                        frame_start = (idx_d <= idx_q);
                        state_d     = StBlank;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase

        if (frame_start) begin
            shadow_d[0] = in0;
            shadow_d[1] = in1;
            shadow_d[2] = in2;
            shadow_d[3] = in3;
        end
    end

    // Outputs are computed from the next state and then registered, so each
    // output cycle lines up exactly with the state held in that cycle.
    always_comb begin
        an_d   = 4'hF;
        sseg_d = 8'hFF;
        if (state_d == StDrive && en_mask[idx_d] &&
            (bright == 4'hF || pwm_d < bright)) begin
            an_d   = ~(4'b0001 << idx_d);
            sseg_d = shadow_d[idx_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            pwm_q      <= 4'd0;
            shadow_q   <= '{default: 8'hFF};
            an         <= 4'hF;
            sseg       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            shadow_q   <= shadow_d;
            an         <= an_d;
            sseg       <= sseg_d;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_disp_scan_ctrl
//
// Directed testbench for disp_scan_ctrl with SCAN_DIV=4 and BLANK_CYC=2.
// Expected per-cycle outputs for one frame come from a table. The table is
// built from the slot layout: two blank cycles, then four drive cycles per
// enabled digit. Hand-written sequences cover tearing, mask edges and reset.
// Outputs are sampled on the falling edge. Edge k is the k-th rising edge
// after reset release.
// ---------------------------------------------------------------------------
module tb_disp_scan_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] en_mask;
    logic [3:0] bright;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] an;
        logic [7:0] sseg;
        logic       ft;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] digs [4];

    disp_scan_ctrl #(
        .SCAN_DIV (4),
        .BLANK_CYC(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .en_mask   (en_mask),
        .bright    (bright),
        .an        (an),
        .sseg      (sseg),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] ea, input logic [7:0] es,
                         input logic ef);
        total++;
        if (an !== ea || sseg !== es || frame_tick !== ef) begin
            bad++;
            $display("FAIL %s @%0t: got an=%b sseg=%h ft=%b, want an=%b sseg=%h ft=%b",
                     name, $time, an, sseg, frame_tick, ea, es, ef);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Assert reset mid-cycle, check the outputs clear at once, then release
    // on a falling edge.
    task automatic apply_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("reset_async", 4'hF, 8'hFF, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Build one frame of expected outputs for mask m.
    task automatic build(input logic [3:0] m);
        logic first;
        tbl.delete();
        first = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (m[d]) begin
                tbl.push_back('{m, 4'hF, 8'hFF, first});
                tbl.push_back('{m, 4'hF, 8'hFF, 1'b0});
                for (int j = 0; j < 4; j++) tbl.push_back('{m, ~(4'b0001 << d), digs[d], 1'b0});
                first = 1'b0;
            end
        end
    endtask

    // Replay the table from reset release. PWM equals edge count mod 16.
    task automatic run_table(input string name, input int nframes, input logic [3:0] br);
        int         k;
        logic [3:0] ea;
        logic [7:0] es;
        bright = br;
        apply_reset();
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < tbl.size(); i++) begin
                en_mask = tbl[i].mask;
                @(negedge clk);
                k  = f * tbl.size() + i + 1;
                ea = tbl[i].an;
                es = tbl[i].sseg;
                if (ea != 4'hF && br != 4'hF && (k % 16) >= int'(br)) begin
                    ea = 4'hF;
                    es = 8'hFF;
                end
                check(name, ea, es, tbl[i].ft);
            end
        end
    endtask

    initial begin
        digs[0] = 8'hC0;
        digs[1] = 8'hF9;
        digs[2] = 8'hA4;
        digs[3] = 8'hB0;
        reset   = 1'b1;
        in0     = 8'hC0;
        in1     = 8'hF9;
        in2     = 8'hA4;
        in3     = 8'hB0;
        en_mask = 4'h0;
        bright  = 4'hF;
        #1 check("reset_init", 4'hF, 8'hFF, 1'b0);
        step(2);
        reset = 1'b0;

        // Idle with nothing enabled.
        step(3);
        check("idle_hold", 4'hF, 8'hFF, 1'b0);

        // Basic scan, all digits: 24-cycle frame.
        build(4'hF);
        run_table("basic", 2, 4'hF);

        // Skip and wrap: 12-cycle frame.
        build(4'b0101);
        run_table("skip_wrap", 3, 4'hF);

        // Single digit: each slot starts a new frame.
        build(4'b0100);
        run_table("single", 3, 4'hF);

        // Dimming.
        build(4'hF);
        run_table("dim4", 2, 4'd4);
        run_table("dim0", 1, 4'd0);
        bright = 4'hF;

        // Tear-free update of in1 in the middle of a frame.
        en_mask = 4'hF;
        apply_reset();
        step(4);
        in1 = 8'h99;
        step(6);
        check("tear_old", 4'b1101, 8'hF9, 1'b0);
        step(15);
        check("tear_tick", 4'hF, 8'hFF, 1'b1);
        step(8);
        check("tear_new", 4'b1101, 8'h99, 1'b0);
        in1 = 8'hF9;

        // Mask edges.
        apply_reset();
        step(4);
        check("mask_pre", 4'b1110, 8'hC0, 1'b0);
        en_mask = 4'h0;
        step(1);
        check("mask_blank", 4'hF, 8'hFF, 1'b0);
        step(1);
        check("mask_blank2", 4'hF, 8'hFF, 1'b0);
        step(3);
        check("mask_idle", 4'hF, 8'hFF, 1'b0);
        en_mask = 4'b1000;
        step(1);
        check("mask8_tick", 4'hF, 8'hFF, 1'b1);
        step(2);
        check("mask8_drive", 4'b0111, 8'hB0, 1'b0);
        step(1);
        en_mask = 4'hF;
        step(3);
        check("restore_tick", 4'hF, 8'hFF, 1'b1);
        step(2);
        check("restore_d0", 4'b1110, 8'hC0, 1'b0);

        // Reset in the middle of DRIVE, then restart at the lowest enabled digit.
        en_mask = 4'hF;
        apply_reset();
        step(4);
        check("rst_pre", 4'b1110, 8'hC0, 1'b0);
        #2 reset = 1'b1;
        #1 check("rst_mid", 4'hF, 8'hFF, 1'b0);
        en_mask = 4'b0110;
        @(negedge clk);
        reset = 1'b0;
        step(1);
        check("rst_tick", 4'hF, 8'hFF, 1'b1);
        step(2);
        check("rst_restart", 4'b1101, 8'hF9, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
